cla_add_sequencer: RTL and testbench

//  Multi-cycle WIDTH-bit add/subtract unit built around one shared 4-bit CLA slice.

---
 rtl/cla_seq_pkg.sv | 18 +
 rtl/cla_add_sequencer_slice.sv | 32 +++
 rtl/cla_add_sequencer.sv | 120 ++++++++++++
 tb/tb_cla_add_sequencer.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/cla_seq_pkg.sv
// Shared types and sizing helpers for the nibble-serial CLA add/sub sequencer.
package cla_seq_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  function automatic int nib_of(input int w);
    return w / 4;
  endfunction

  function automatic int idx_w(input int nib);
    return (nib > 1) ? $clog2(nib) : 1;
  endfunction

endpackage

// File: rtl/cla_add_sequencer_slice.sv
// Combinational 4-bit carry-lookahead slice: sum plus group propagate/generate.
module cla_slice_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       p,
  output logic       g
);

  logic [3:0] w_p;
  logic [3:0] w_g;
  logic [3:0] w_c;

  assign w_p = a ^ b;
  assign w_g = a & b;

  assign w_c[0] = cin;
  assign w_c[1] = w_g[0] | (w_p[0] & cin);
  assign w_c[2] = w_g[1] | (w_p[1] & w_g[0])
                | (&w_p[1:0] & cin);
  assign w_c[3] = w_g[2] | (w_p[2] & w_g[1])
                | (&w_p[2:1] & w_g[0])
                | (&w_p[2:0] & cin);

  assign sum = w_p ^ w_c;
  assign p   = &w_p;
  assign g   = w_g[3] | (w_p[3] & w_g[2])
             | (&w_p[3:2] & w_g[1])
             | (&w_p[3:1] & w_g[0]);

endmodule

// File: rtl/cla_add_sequencer.sv
// WIDTH-bit add/sub, one shared CLA nibble slice per cycle, LSB first.
// Define CLA_SEQ_OVF_EN to add the signed-overflow output ovf.
module cla_add_sequencer
  import cla_seq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             busy
`ifdef CLA_SEQ_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int NIB   = nib_of(WIDTH);
  localparam int IDX_W = idx_w(NIB);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NIB - 1);

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_result;
  logic [IDX_W-1:0] r_idx;
  logic             r_carry;
  logic             r_cout;

  logic [3:0] w_a_nib;
  logic [3:0] w_b_nib;
  logic [3:0] w_sum;
  logic       w_p;
  logic       w_g;
  logic       w_co;
  logic       w_last;

  assign w_a_nib = r_a[{r_idx, 2'b00} +: 4];
  assign w_b_nib = r_b[{r_idx, 2'b00} +: 4];

  cla_slice_4bit u_slice (
    .a   (w_a_nib),
    .b   (w_b_nib),
    .cin (r_carry),
    .sum (w_sum),
    .p   (w_p),
    .g   (w_g)
  );

  assign w_co   = w_g | (w_p & r_carry);
  assign w_last = (r_idx == LAST);

`ifdef CLA_SEQ_OVF_EN
  logic r_ovf;
  assign ovf = r_ovf;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_result <= '0;
      r_idx    <= '0;
      r_carry  <= 1'b0;
      r_cout   <= 1'b0;
`ifdef CLA_SEQ_OVF_EN
      r_ovf    <= 1'b0;
`endif
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start_valid) begin
            r_a     <= a;
            r_b     <= b ^ {WIDTH{sub}};
            r_carry <= sub;
            r_idx   <= '0;
            r_state <= S_RUN;
`ifdef CLA_SEQ_OVF_EN
            r_ovf   <= 1'b0;
`endif
          end
        end
        S_RUN: begin
          r_result[{r_idx, 2'b00} +: 4] <= w_sum;
          r_carry <= w_co;
          r_idx   <= r_idx + 1'b1;
          if (w_last) begin
            r_cout  <= w_co;
            r_state <= S_DONE;
`ifdef CLA_SEQ_OVF_EN
            // b is already inverted for sub, so one rule covers both ops
            r_ovf <= (r_a[WIDTH-1] == r_b[WIDTH-1])
                  && (w_sum[3] != r_a[WIDTH-1]);
`endif
          end
        end
        S_DONE: begin
          if (res_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign start_ready = (r_state == S_IDLE);
  assign res_valid   = (r_state == S_DONE);
  assign busy        = (r_state != S_IDLE);
  assign result      = r_result;
  assign cout        = r_cout;

endmodule

// File: tb/tb_cla_add_sequencer.sv
// Directed scoreboard bench for cla_add_sequencer at WIDTH=32.
// Build with CLA_SEQ_OVF_EN defined to also cover the ovf output.
module tb_cla_add_sequencer;

  typedef struct packed {
    logic [31:0] res;
    logic        co;
    logic        ov;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        start_valid;
  logic        start_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        sub;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] result;
  logic        cout;
  logic        busy;
`ifdef CLA_SEQ_OVF_EN
  logic        ovf;
`endif

  int   errors = 0;
  int   checks = 0;
  exp_t sbq[$];

  cla_add_sequencer #(.WIDTH(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .a           (a),
    .b           (b),
    .sub         (sub),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .result      (result),
    .cout        (cout),
    .busy        (busy)
`ifdef CLA_SEQ_OVF_EN
    ,
    .ovf         (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t model(input logic [31:0] ta,
                                 input logic [31:0] tb_,
                                 input logic ts);
    exp_t        e;
    logic [31:0] bp;
    logic [32:0] s;
    bp = ts ? ~tb_ : tb_;
    s = {1'b0, ta} + {1'b0, bp} + {32'd0, ts};
    e.res = s[31:0];
    e.co  = s[32];
    e.ov  = (ta[31] == bp[31]) && (s[31] != ta[31]);
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input logic [31:0] ta, input logic [31:0] tb_,
                        input logic ts, input bit hold);
    int   n;
    exp_t e;
    n = 0;
    while (!start_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("start_ready", 32'(start_ready), 32'd1);
    @(negedge clk);
    a = ta;
    b = tb_;
    sub = ts;
    start_valid = 1'b1;
    @(posedge clk);
    sbq.push_back(model(ta, tb_, ts));
    #1;
    start_valid = 1'b0;
    a = $urandom;
    b = $urandom;
    sub = 1'($urandom);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!res_valid && n < 40);
    chk("latency", 32'(n), 32'd8);
    e = sbq.pop_front();
    chk("result", result, e.res);
    chk("cout", 32'(cout), 32'(e.co));
`ifdef CLA_SEQ_OVF_EN
    chk("ovf", 32'(ovf), 32'(e.ov));
`endif
    if (!hold) begin
      @(negedge clk);
      res_ready = 1'b1;
      @(posedge clk);
      #1;
      res_ready = 1'b0;
      chk("res_valid_drop", 32'(res_valid), 32'd0);
    end
  endtask

  initial begin
    logic [31:0] held;
    int          n;
    rst_n = 1'b0;
    start_valid = 1'b0;
    res_ready = 1'b0;
    a = '0;
    b = '0;
    sub = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_result", result, 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
`ifdef CLA_SEQ_OVF_EN
    chk("rst_ovf", 32'(ovf), 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_start_ready", 32'(start_ready), 32'd1);

    res_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("stray_res_ready", 32'(busy), 32'd0);
    res_ready = 1'b0;

    run_op(32'h00000005, 32'h00000003, 1'b0, 1'b0);
    run_op(32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0);
    run_op(32'h00000003, 32'h00000005, 1'b1, 1'b0);
    run_op(32'h00000005, 32'h00000003, 1'b1, 1'b0);
    run_op(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0);
    run_op(32'h80000000, 32'h00000001, 1'b1, 1'b0);
    run_op(32'h0F0F0F0F, 32'hF0F0F0F1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++)
      run_op($urandom, $urandom, 1'(i), 1'b0);

    // hold in DONE while poking inputs
    run_op(32'h12345678, 32'h11111111, 1'b0, 1'b1);
    held = result;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      start_valid = ~start_valid;
      a = $urandom;
      b = $urandom;
      @(posedge clk);
      #1;
      chk("hold_result", result, held);
      chk("hold_start_ready", 32'(start_ready), 32'd0);
      chk("hold_res_valid", 32'(res_valid), 32'd1);
    end
    @(negedge clk);
    start_valid = 1'b0;
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    res_ready = 1'b0;
    chk("release_res_valid", 32'(res_valid), 32'd0);
    chk("release_start_ready", 32'(start_ready), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    chk("no_queued_op", 32'(busy), 32'd0);

    // reset mid-RUN at idx=4
    @(negedge clk);
    a = 32'hFFFFFFFF;
    b = 32'hFFFFFFFF;
    sub = 1'b0;
    start_valid = 1'b1;
    @(posedge clk);
    #1;
    start_valid = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_result", result, 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_res_valid", 32'(res_valid), 32'd0);
    chk("mid_rst_cout", 32'(cout), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0);

    n = sbq.size();
    chk("sb_empty", 32'(n), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
